// File: rtl/knn_sample_reader.sv
// Read-side companion to the KNN time-counter core: strobes a sample, captures the
// 2*DATA_W value and returns it (absolute or delta) as two DATA_W beats, low first.
module knn_sample_reader #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_mode,
    output logic                req_ready,
    output logic                KNN_SAMPLE,
    input  logic [2*DATA_W-1:0] KNN_VALUE,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAMPLE  = 3'd1,
        CAPTURE = 3'd2,
        SEND_LO = 3'd3,
        SEND_HI = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [2*DATA_W-1:0]   snap_q, snap_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  knn_sample_q, knn_sample_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  rd_last_q, rd_last_d;

    // snap_q holds the most recent capture and is also the reference for the next delta.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        snap_d   = snap_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mode_d  = req_mode;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: state_d = CAPTURE;
            CAPTURE: begin
                snap_d   = KNN_VALUE;
                result_d = mode_q ? (KNN_VALUE - snap_q) : KNN_VALUE;
                state_d  = SEND_LO;
            end
            SEND_LO: if (rd_ready) state_d = SEND_HI;
            SEND_HI: if (rd_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        knn_sample_d = (state_d == SAMPLE);
        rd_valid_d   = (state_d == SEND_LO) || (state_d == SEND_HI);
        rd_last_d    = (state_d == SEND_HI);
        rd_data_d    = '0;
        case (state_d)
            SEND_LO: rd_data_d = result_d[DATA_W-1:0];
            SEND_HI: rd_data_d = result_d[2*DATA_W-1:DATA_W];
            default: rd_data_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            snap_q       <= '0;
            result_q     <= '0;
            knn_sample_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            snap_q       <= snap_d;
            result_q     <= result_d;
            knn_sample_q <= knn_sample_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_last_q    <= rd_last_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign KNN_SAMPLE = knn_sample_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_last    = rd_last_q;

endmodule

// File: tb/tb_knn_sample_reader.sv
// Bench for knn_sample_reader: counter stub plus a capture/delta reference model.
module tb_knn_sample_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_mode = 1'b0;
    logic        rd_ready = 1'b0;
    logic        req_ready, KNN_SAMPLE, rd_valid, rd_last;
    logic [31:0] rd_data;

    logic [63:0] ctr = '0;
    logic [63:0] stub = '0;
    logic [63:0] ctr_load_val = '0;
    logic [63:0] force_val = '0;
    logic        ctr_load = 1'b0;
    logic        force_en = 1'b0;
    int          samples = 0;
    int          beats = 0;
    int          vectors = 0;
    int          errs = 0;
    logic [63:0] m_prev = '0;

    knn_sample_reader #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_mode(req_mode), .req_ready(req_ready),
        .KNN_SAMPLE(KNN_SAMPLE), .KNN_VALUE(stub),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    // Free-running counter core stub; latches its value on the sample strobe.
    always @(posedge clk) begin
        ctr <= ctr_load ? ctr_load_val : ctr + 64'd1;
        if (KNN_SAMPLE) begin
            stub    <= force_en ? force_val : ctr;
            samples <= samples + 1;
        end
        if (rd_valid && rd_ready) beats <= beats + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic mode, input logic [63:0] v, output logic [63:0] e);
        e = mode ? (v - m_prev) : v;
        m_prev = v;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
    endtask

    // Fixed-latency request with rd_ready held high.
    task automatic req_timed(input logic mode, input logic [63:0] v);
        logic [63:0] e;
        int s0;
        model_step(mode, v, e);
        wait_ready();
        s0 = samples;
        rd_ready = 1'b1; req_valid = 1'b1; req_mode = mode;
        tick();
        req_valid = 1'b0;
        chk("t1_sample", {63'd0, KNN_SAMPLE}, 64'd1);
        chk("t1_req_ready", {63'd0, req_ready}, 64'd0);
        chk("t1_rd_valid", {63'd0, rd_valid}, 64'd0);
        tick();
        chk("t2_sample", {63'd0, KNN_SAMPLE}, 64'd0);
        chk("t2_rd_valid", {63'd0, rd_valid}, 64'd0);
        tick();
        chk("t3_rd_valid", {63'd0, rd_valid}, 64'd1);
        chk("t3_lo", {32'd0, rd_data}, {32'd0, e[31:0]});
        chk("t3_last", {63'd0, rd_last}, 64'd0);
        tick();
        chk("t4_rd_valid", {63'd0, rd_valid}, 64'd1);
        chk("t4_hi", {32'd0, rd_data}, {32'd0, e[63:32]});
        chk("t4_last", {63'd0, rd_last}, 64'd1);
        tick();
        chk("t5_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("t5_req_ready", {63'd0, req_ready}, 64'd1);
        chk("t_sample_count", 64'(samples - s0), 64'd1);
    endtask

    // Randomly stalled request; beats collected at each handshake.
    task automatic xact(input logic mode, input logic [63:0] v, input int stall_pct);
        logic [63:0] e;
        logic [31:0] b [2];
        logic        l [2];
        int nb = 0, n = 0, s0, b0;
        model_step(mode, v, e);
        force_en = 1'b1; force_val = v;
        wait_ready();
        s0 = samples; b0 = beats;
        req_valid = 1'b1; req_mode = mode;
        rd_ready = ($urandom_range(99) >= 32'(stall_pct));
        tick();
        req_valid = 1'b0;
        while (nb < 2 && n < 200) begin
            rd_ready = ($urandom_range(99) >= 32'(stall_pct));
            if (rd_valid && rd_ready) begin
                b[nb] = rd_data;
                l[nb] = rd_last;
                nb++;
            end
            tick();
            n++;
        end
        rd_ready = 1'b0;
        chk("x_beat_count", 64'(nb), 64'd2);
        chk("x_lo", {32'd0, b[0]}, {32'd0, e[31:0]});
        chk("x_lo_last", {63'd0, l[0]}, 64'd0);
        chk("x_hi", {32'd0, b[1]}, {32'd0, e[63:32]});
        chk("x_hi_last", {63'd0, l[1]}, 64'd1);
        chk("x_sample_count", 64'(samples - s0), 64'd1);
        chk("x_handshakes", 64'(beats - b0), 64'd2);
    endtask

    // Long stalls in both beats with req_valid held asserted throughout.
    task automatic backpressure(input logic mode, input logic [63:0] v);
        logic [63:0] e;
        int s0, b0;
        model_step(mode, v, e);
        force_en = 1'b1; force_val = v;
        wait_ready();
        s0 = samples; b0 = beats;
        rd_ready = 1'b0; req_valid = 1'b1; req_mode = mode;
        repeat (3) tick();
        chk("bp_lo_valid", {63'd0, rd_valid}, 64'd1);
        chk("bp_lo", {32'd0, rd_data}, {32'd0, e[31:0]});
        repeat (7) begin
            tick();
            chk("bp_lo_stable", {32'd0, rd_data}, {32'd0, e[31:0]});
            chk("bp_lo_last", {63'd0, rd_last}, 64'd0);
            chk("bp_lo_req_ready", {63'd0, req_ready}, 64'd0);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("bp_hi_valid", {63'd0, rd_valid}, 64'd1);
        repeat (7) begin
            tick();
            chk("bp_hi_stable", {32'd0, rd_data}, {32'd0, e[63:32]});
            chk("bp_hi_last", {63'd0, rd_last}, 64'd1);
            chk("bp_hi_req_ready", {63'd0, req_ready}, 64'd0);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        req_valid = 1'b0;
        chk("bp_done_valid", {63'd0, rd_valid}, 64'd0);
        chk("bp_done_req_ready", {63'd0, req_ready}, 64'd1);
        chk("bp_sample_count", 64'(samples - s0), 64'd1);
        chk("bp_handshakes", 64'(beats - b0), 64'd2);
    endtask

    initial begin
        logic [63:0] v;
        #3 rst = 1'b0;
        #1;
        chk("rst_sample", {63'd0, KNN_SAMPLE}, 64'd0);
        chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("rst_rd_last", {63'd0, rd_last}, 64'd0);
        chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();
        chk("rel_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rel_sample", {63'd0, KNN_SAMPLE}, 64'd0);
        m_prev = '0;

        // First delta after reset equals the absolute value.
        force_en = 1'b1; force_val = 64'h0000_0000_0000_1234;
        req_timed(1'b1, 64'h0000_0000_0000_1234);

        // Absolute read off the live counter; strobe lands one cycle after acceptance.
        force_en = 1'b0;
        ctr_load = 1'b1; ctr_load_val = 64'h0000_0001_FFFF_FFF0;
        tick();
        ctr_load = 1'b0;
        req_timed(1'b0, 64'h0000_0001_FFFF_FFF1);

        // Delta across the 64-bit wrap.
        force_en = 1'b1; force_val = 64'hFFFF_FFFF_FFFF_FFFE;
        req_timed(1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
        force_val = 64'h0000_0000_0000_0003;
        req_timed(1'b1, 64'h0000_0000_0000_0003);

        backpressure(1'($urandom_range(1)), {$urandom(), $urandom()});

        for (int i = 0; i < 24; i++)
            xact(1'($urandom_range(1)), {$urandom(), $urandom()}, 40);

        // Reset while the strobe is high: strobe drops at once.
        wait_ready();
        rd_ready = 1'b0; req_valid = 1'b1; req_mode = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("mid_sample_hi", {63'd0, KNN_SAMPLE}, 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_sample_drop", {63'd0, KNN_SAMPLE}, 64'd0);
        @(negedge clk) rst = 1'b1;
        tick();

        // Reset during SEND_LO: beat withdrawn, prev cleared.
        force_val = {$urandom(), $urandom()};
        wait_ready();
        req_valid = 1'b1; req_mode = 1'b0;
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        chk("mid_lo_valid", {63'd0, rd_valid}, 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("mid_rd_last", {63'd0, rd_last}, 64'd0);
        chk("mid_rd_data", {32'd0, rd_data}, 64'd0);
        m_prev = '0;
        @(negedge clk) rst = 1'b1;
        tick();
        chk("mid_rel_req_ready", {63'd0, req_ready}, 64'd1);
        chk("mid_rel_sample", {63'd0, KNN_SAMPLE}, 64'd0);
        v = {$urandom(), $urandom()};
        force_val = v;
        req_timed(1'b1, v);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, %0d vectors applied", vectors);
        $fatal(1, "timeout");
    end

endmodule
